ww_test_storage: RTL and testbench

Parametrised test-storage block for the ww machine: a bank of 2**ADDR_W words.
- Every word reads from a toggle-switch register by default.
- N_FF flip-flop registers can each be mapped onto any address, overriding the switch word there; they are writable.
- A sequencer reloads the flip-flop registers from their preset switches after reset or on a storage_reset request.
- Sits beside core memory and serves the control's memory requests through a req/ack handshake.

---
 rtl/ww_pkg.sv | 22 ++
 rtl/ww_ts_decode.sv | 27 ++
 rtl/ww_test_storage.sv | 139 +++++++++++++
 tb/tb_ww_test_storage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ww_pkg.sv
// rtl/ww_pkg.sv - shared types and sizing for the ww test-storage block
package ww_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_FF   = 5;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;
  localparam int IDX_W      = (DEF_N_FF > 1) ? $clog2(DEF_N_FF) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RELOAD = 2'd1,
    ACCESS = 2'd2,
    ACK    = 2'd3
  } ts_state_t;

  // Index width that stays at least one bit for a single flip-flop register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ww_ts_decode.sv
// rtl/ww_ts_decode.sv - maps an address onto the flip-flop registers placed there
module ww_ts_decode
  import ww_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_FF   = DEF_N_FF,
  parameter int IW     = idx_width(DEF_N_FF)
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic [N_FF*ADDR_W-1:0] sw_ff_addr,
  output logic [N_FF-1:0]        hit,
  output logic [IW-1:0]          first_idx
);

  // Scan downwards so the lowest-index match is the one that sticks.
  always_comb begin
    hit       = '0;
    first_idx = '0;
    for (int k = N_FF - 1; k >= 0; k--) begin
      if (sw_ff_addr[k*ADDR_W +: ADDR_W] == addr) begin
        hit[k]    = 1'b1;
        first_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/ww_test_storage.sv
// rtl/ww_test_storage.sv - toggle-switch test storage with mappable flip-flop registers
module ww_test_storage
  import ww_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_FF   = DEF_N_FF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [(2**ADDR_W)*WIDTH-1:0]    sw_ts,
  input  logic [N_FF*WIDTH-1:0]           sw_ff_preset,
  input  logic [N_FF*ADDR_W-1:0]          sw_ff_addr,
  input  logic                            storage_reset,
  input  logic                            req,
  input  logic                            we,
  input  logic [ADDR_W-1:0]               addr,
  input  logic [WIDTH-1:0]                wdata,
  output logic                            ack,
  output logic [WIDTH-1:0]                rdata,
  output logic                            wr_ignored,
  output logic                            busy,
  output logic [N_FF*WIDTH-1:0]           ff_q
);

  localparam int IW = idx_width(N_FF);

  ts_state_t          state_q;
  logic [IW-1:0]      idx_q;
  logic [WIDTH-1:0]   ffs_q [N_FF];
  logic               ack_q, wr_ign_q, busy_q, pend_q, sr_prev_q;
  logic [WIDTH-1:0]   rdata_q, wdata_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;

  logic [N_FF-1:0]    hit;
  logic [IW-1:0]      first_idx;
  logic               sr_edge;
  logic [WIDTH-1:0]   ts_word, preset_word;

  ww_ts_decode #(.ADDR_W(ADDR_W), .N_FF(N_FF), .IW(IW)) u_decode (
    .addr       (addr_q),
    .sw_ff_addr (sw_ff_addr),
    .hit        (hit),
    .first_idx  (first_idx)
  );

  // storage_reset is already synchronous to clk, so a single history bit suffices.
  assign sr_edge     = storage_reset & ~sr_prev_q;
  assign ts_word     = sw_ts[addr_q*WIDTH +: WIDTH];
  assign preset_word = sw_ff_preset[idx_q*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RELOAD;
      idx_q     <= '0;
      for (int k = 0; k < N_FF; k++) ffs_q[k] <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      wr_ign_q  <= 1'b0;
      busy_q    <= 1'b1;
      pend_q    <= 1'b0;
      sr_prev_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      sr_prev_q <= storage_reset;
      case (state_q)
        RELOAD: begin
          if (sr_edge) begin
            idx_q <= '0;
          end else begin
            ffs_q[idx_q] <= preset_word;
            if (idx_q == IW'(N_FF - 1)) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              pend_q  <= 1'b0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        IDLE: begin
          if (sr_edge || pend_q) begin
            state_q <= RELOAD;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            pend_q  <= 1'b0;
          end else if (req) begin
            we_q    <= we;
            addr_q  <= addr;
            wdata_q <= wdata;
            state_q <= ACCESS;
            busy_q  <= 1'b1;
          end
        end
        ACCESS: begin
          if (sr_edge) pend_q <= 1'b1;
          if (we_q) begin
            for (int k = 0; k < N_FF; k++) begin
              if (hit[k]) ffs_q[k] <= wdata_q;
            end
            wr_ign_q <= ~|hit;
          end else begin
            rdata_q  <= (|hit) ? ffs_q[first_idx] : ts_word;
            wr_ign_q <= 1'b0;
          end
          ack_q   <= 1'b1;
          state_q <= ACK;
        end
        ACK: begin
          ack_q    <= 1'b0;
          wr_ign_q <= 1'b0;
          if (pend_q || sr_edge) begin
            state_q <= RELOAD;
            idx_q   <= '0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < N_FF; g++) begin : g_pack
    assign ff_q[g*WIDTH +: WIDTH] = ffs_q[g];
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign wr_ignored = wr_ign_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ww_test_storage.sv
// tb/tb_ww_test_storage.sv - directed self-checking bench for ww_test_storage
module tb_ww_test_storage;

  localparam int W  = 16;
  localparam int AW = 5;
  localparam int NF = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [32*W-1:0]   sw_ts;
  logic [NF*W-1:0]   sw_ff_preset;
  logic [NF*AW-1:0]  sw_ff_addr;
  logic              storage_reset, req, we;
  logic [AW-1:0]     addr;
  logic [W-1:0]      wdata;
  logic              ack;
  logic [W-1:0]      rdata;
  logic              wr_ignored, busy;
  logic [NF*W-1:0]   ff_q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ww_test_storage #(.WIDTH(W), .ADDR_W(AW), .N_FF(NF)) dut (
    .clk           (clk),
    .reset         (reset),
    .sw_ts         (sw_ts),
    .sw_ff_preset  (sw_ff_preset),
    .sw_ff_addr    (sw_ff_addr),
    .storage_reset (storage_reset),
    .req           (req),
    .we            (we),
    .addr          (addr),
    .wdata         (wdata),
    .ack           (ack),
    .rdata         (rdata),
    .wr_ignored    (wr_ignored),
    .busy          (busy),
    .ff_q          (ff_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_access(input logic w, input logic [AW-1:0] a, input logic [W-1:0] d,
                           output logic [W-1:0] rd, output logic wi, output int edges);
    req = 1'b1; we = w; addr = a; wdata = d; edges = 0;
    while (!ack && edges < 10) begin
      tick();
      edges++;
    end
    checks++;
    if (ack !== 1'b1) begin
      errors++;
      $display("FAIL access_ack_timeout addr=%0d got ack=%b want 1", a, ack);
    end
    rd = rdata; wi = wr_ignored;
    req = 1'b0;
    tick();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (ff_q !== '0 || ack !== 1'b0 || busy !== 1'b1 || rdata !== '0 || wr_ignored !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ff_q=%h ack=%b busy=%b rdata=%o wi=%b want 0/0/1/0/0",
               ff_q, ack, busy, rdata, wr_ignored);
    end
    reset = 1'b1;
    count_busy(n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL boot_busy_cycles got %0d want 5", n); end
    checks++;
    if (ff_q !== {16'o0, 16'o177777, 16'o22, 16'o11, 16'o1000}) begin
      errors++;
      $display("FAIL boot_ff_load got %h want %h", ff_q, {16'o0, 16'o177777, 16'o22, 16'o11, 16'o1000});
    end
  endtask

  task automatic test_boot_read();
    logic [W-1:0] rd; logic wi; int e;
    do_access(1'b0, 5'd3, '0, rd, wi, e);
    checks++;
    if (rd !== 16'o177777) begin errors++; $display("FAIL read_ff3 got %o want 177777", rd); end
    checks++;
    if (e !== 2) begin errors++; $display("FAIL ack_latency got %0d edges want 2", e); end
    do_access(1'b0, 5'd25, '0, rd, wi, e);
    checks++;
    if (rd !== 16'o103744 || wi !== 1'b0) begin
      errors++; $display("FAIL read_sw25 got %o wi=%b want 103744 wi=0", rd, wi);
    end
  endtask

  task automatic test_write_reload();
    logic [W-1:0] rd; logic wi; int e, n;
    do_access(1'b1, 5'd4, 16'o012345, rd, wi, e);
    checks++;
    if (wi !== 1'b0 || ff_q[4*W +: W] !== 16'o012345) begin
      errors++; $display("FAIL write_ff4 got ff4=%o wi=%b want 12345 wi=0", ff_q[4*W +: W], wi);
    end
    storage_reset = 1'b1;
    tick();
    storage_reset = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 5) begin errors++; $display("FAIL reload_busy_cycles got %0d want 5", n); end
    checks++;
    if (ff_q[4*W +: W] !== 16'o0) begin
      errors++; $display("FAIL reload_ff4 got %o want 0", ff_q[4*W +: W]);
    end
  endtask

  task automatic test_write_switch();
    logic [W-1:0] rd; logic wi; int e;
    do_access(1'b1, 5'd26, 16'o777, rd, wi, e);
    checks++;
    if (wi !== 1'b1) begin errors++; $display("FAIL write_switch_ignored got %b want 1", wi); end
    do_access(1'b0, 5'd26, '0, rd, wi, e);
    checks++;
    if (rd !== 16'o047743) begin errors++; $display("FAIL read_sw26 got %o want 47743", rd); end
  endtask

  task automatic test_reload_during_access();
    int n;
    req = 1'b1; we = 1'b1; addr = 5'd3; wdata = 16'o1;
    tick();
    storage_reset = 1'b1;
    tick();
    checks++;
    if (ack !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL pend_access_ack got ack=%b busy=%b want 1/1", ack, busy);
    end
    req = 1'b0; storage_reset = 1'b0;
    tick();
    checks++;
    if (ack !== 1'b0 || busy !== 1'b1 || ff_q[3*W +: W] !== 16'o1) begin
      errors++;
      $display("FAIL pend_after_ack got ack=%b busy=%b ff3=%o want 0/1/1", ack, busy, ff_q[3*W +: W]);
    end
    count_busy(n);
    checks++;
    if (n !== 5 || ff_q[3*W +: W] !== 16'o177777) begin
      errors++; $display("FAIL pend_reload got busy=%0d ff3=%o want 5/177777", n, ff_q[3*W +: W]);
    end
  endtask

  task automatic test_alias();
    logic [W-1:0] rd; logic wi; int e;
    sw_ff_addr[1*AW +: AW] = 5'd7;
    sw_ff_addr[2*AW +: AW] = 5'd7;
    do_access(1'b0, 5'd7, '0, rd, wi, e);
    checks++;
    if (rd !== 16'o11) begin errors++; $display("FAIL alias_read got %o want 11", rd); end
    do_access(1'b1, 5'd7, 16'o55, rd, wi, e);
    checks++;
    if (ff_q[1*W +: W] !== 16'o55 || ff_q[2*W +: W] !== 16'o55 || ff_q[0 +: W] !== 16'o1000 || wi !== 1'b0) begin
      errors++;
      $display("FAIL alias_write got ff0=%o ff1=%o ff2=%o wi=%b want 1000/55/55/0",
               ff_q[0 +: W], ff_q[1*W +: W], ff_q[2*W +: W], wi);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    req = 1'b1; we = 1'b0; addr = 5'd25;
    e = 0;
    while (!ack && e < 10) begin tick(); e++; end
    e = 0;
    tick();
    while (!ack && e < 10) begin tick(); e++; end
    checks++;
    if (ack !== 1'b1 || e !== 2 || rdata !== 16'o103744) begin
      errors++; $display("FAIL back_to_back got ack=%b gap=%0d rdata=%o want 1/2/103744", ack, e, rdata);
    end
    req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_ops();
    int n;
    req = 1'b1; we = 1'b0; addr = 5'd25;
    tick(); tick();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0 || busy !== 1'b1 || ff_q !== '0) begin
      errors++; $display("FAIL reset_mid_access got ack=%b busy=%b ff_q=%h want 0/1/0", ack, busy, ff_q);
    end
    req = 1'b0;
    #1 reset = 1'b1;
    count_busy(n);
    storage_reset = 1'b1;
    tick();
    storage_reset = 1'b0;
    tick(); tick();
    #1 reset = 1'b0;
    #1;
    checks++;
    if (ff_q !== '0 || ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid_reload got ff_q=%h ack=%b want 0/0", ff_q, ack);
    end
    #1 reset = 1'b1;
    count_busy(n);
    checks++;
    if (n !== 5 || ff_q !== {16'o0, 16'o177777, 16'o22, 16'o11, 16'o1000}) begin
      errors++; $display("FAIL reset_reload_full got busy=%0d ff_q=%h want 5 full presets", n, ff_q);
    end
  endtask

  initial begin
    reset = 1'b0; storage_reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 32; i++) sw_ts[i*W +: W] = W'(16'h1000 + i);
    sw_ts[25*W +: W] = 16'o103744;
    sw_ts[26*W +: W] = 16'o047743;
    sw_ff_preset = {16'o0, 16'o177777, 16'o22, 16'o11, 16'o1000};
    sw_ff_addr   = {5'd4, 5'd3, 5'd12, 5'd11, 5'd10};
    test_reset();
    test_boot_read();
    test_write_reload();
    test_write_switch();
    test_reload_during_access();
    test_back_to_back();
    test_alias();
    test_reset_mid_ops();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
